// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding, parity-mode constants and
// the baud counter width helper used by both the TX and RX paths.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic PARITY_MODE_EVEN = 1'b0;
   localparam logic PARITY_MODE_ODD  = 1'b1;

   // A counter for 0..clks_per_bit-1 needs at least one bit even when clks_per_bit is 2.
   function automatic int baud_cnt_width(input int clks_per_bit);
      return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period. Held at zero when disabled or cleared.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int CW           = baud_cnt_width(CLKS_PER_BIT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   output logic          bit_end,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   assign bit_end = en && (count == LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (clr || !en || bit_end) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: accepts one word per frame over valid/ready and serialises
// it as start bit, data LSB-first, optional parity and one or two stop bits.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int            CW        = baud_cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
   localparam logic          ODD_SENSE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

   tx_state_e            state;
   tx_state_e            state_nx;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shift_nx;
   logic [3:0]           bit_idx;
   logic [3:0]           bit_idx_nx;
   logic                 stop_cnt;
   logic                 stop_cnt_nx;
   logic                 parity;
   logic                 parity_nx;
   logic                 tx_nx;
   logic                 ready_nx;
   logic                 accept;
   logic                 bit_end;
   logic [CW-1:0]        baud_count;

   // Handshake: a word transfers on a rising edge where tx_valid and tx_ready are
   // both high; tx_ready is high only in IDLE, and tx_valid may drop unaccepted.
   assign accept = tx_valid && tx_ready;
   assign busy   = (state != IDLE);
   assign done   = rst && (state == STOP) && (stop_cnt == LAST_STOP) && (baud_count == BAUD_LAST);

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .CW           (CW)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .en      (busy),
      .clr     (accept),
      .bit_end (bit_end),
      .count   (baud_count)
   );

   always_comb begin
      state_nx    = state;
      shift_nx    = shift;
      bit_idx_nx  = bit_idx;
      stop_cnt_nx = stop_cnt;
      parity_nx   = parity;

      case (state)
         IDLE: begin
            if (accept) begin
               state_nx    = START;
               shift_nx    = tx_data;
               bit_idx_nx  = '0;
               stop_cnt_nx = 1'b0;
               parity_nx   = (^tx_data) ^ ODD_SENSE;
            end
         end
         START: begin
            if (bit_end) state_nx = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_nx = shift >> 1;
               if (bit_idx == LAST_BIT) begin
                  bit_idx_nx = '0;
                  state_nx   = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_idx_nx = bit_idx + 4'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_nx = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (stop_cnt == LAST_STOP) begin
                  state_nx = IDLE;
               end else begin
                  stop_cnt_nx = stop_cnt + 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      // tx is registered from the level the next state will drive, so it only
      // moves on bit boundaries.
      case (state_nx)
         START:   tx_nx = 1'b0;
         DATA:    tx_nx = shift_nx[0];
         PARITY:  tx_nx = parity_nx;
         default: tx_nx = 1'b1;
      endcase

      ready_nx = (state_nx == IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         shift    <= '0;
         bit_idx  <= '0;
         stop_cnt <= 1'b0;
         parity   <= 1'b0;
         tx       <= 1'b1;
         tx_ready <= 1'b0;
      end else begin
         state    <= state_nx;
         shift    <= shift_nx;
         bit_idx  <= bit_idx_nx;
         stop_cnt <= stop_cnt_nx;
         parity   <= parity_nx;
         tx       <= tx_nx;
         tx_ready <= ready_nx;
      end
   end

endmodule
